gcd_loader: RTL and testbench
=============================

GCD_LOADER -- requirements
Module: gcd_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning operand and data_in width.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles between the A and B load pulses (0 allowed).
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning the maximum WAIT_DONE cycles before abort (>=2).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1, host operand pair valid.
REQ-007 SHALL have port req_ready, output, 1, loader can accept a pair.
REQ-008 SHALL have port req_a, input, DATA_W, first operand.
REQ-009 SHALL have port req_b, input, DATA_W, second operand.
REQ-010 SHALL have port start, output, 1, load strobe to the GCD core.
REQ-011 SHALL have port data_in, output, DATA_W, operand bus to the GCD core.
REQ-012 SHALL have port done, input, 1, completion from the GCD core.
REQ-013 SHALL have port rsp_valid, output, 1, response available.
REQ-014 SHALL have port rsp_ready, input, 1, host accepts the response.
REQ-015 SHALL have port rsp_status, output, 2, 00=ok, 01=timeout, 10=zero-operand error.
REQ-016 SHALL have port rsp_cycles, output, 16, WAIT_DONE cycle count, saturating at 16'hFFFF.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD_A, GAP, LOAD_B, WAIT_DONE, RESP.
REQ-018 SHALL assert req_ready only in IDLE; a transfer occurs on req_valid && req_ready, and req_a/req_b are captured into internal registers.
REQ-019 SHALL, on a transfer with req_a==0 or req_b==0, go directly to RESP with status 10 and cycles 0, with no start pulse.
REQ-020 SHALL otherwise go to LOAD_A, so that start is high in the cycle after acceptance.
REQ-021 SHALL, in LOAD_A, drive start=1 and data_in=A for exactly one cycle, then enter GAP, or LOAD_B directly when GAP_CYCLES==0.
REQ-022 SHALL, in GAP, drive start=0 and data_in=0 for exactly GAP_CYCLES cycles, then enter LOAD_B.
REQ-023 SHALL, in LOAD_B, drive start=1 and data_in=B for exactly one cycle, then enter WAIT_DONE with the cycle counter cleared to 0.
REQ-024 SHALL drive start=0 and data_in=0 in every state except LOAD_A and LOAD_B; start and data_in are registered outputs.
REQ-025 SHALL, in WAIT_DONE, increment the counter every cycle that done is low.
REQ-026 SHALL, on done==1 in WAIT_DONE, latch the count and status 00, then enter RESP.
REQ-027 SHALL, when the count reaches TIMEOUT-1 with done low, enter RESP with status 01.
REQ-028 SHALL give priority to done when done and the timeout occur in the same cycle (status 00).
REQ-029 SHALL ignore done while in IDLE, LOAD_A, GAP, LOAD_B and RESP.
REQ-030 SHALL, in RESP, hold rsp_valid=1 with stable rsp_status and rsp_cycles until rsp_ready.
REQ-031 SHALL return to IDLE on the rsp_ready handshake; req_ready rises the next cycle, with no back-to-back accept in the same cycle.
REQ-032 SHALL hold rsp_status and rsp_cycles at their last value outside RESP.

Reset
REQ-033 SHALL, when rst is high at a clock edge, enter IDLE and drive start=0, data_in=0, rsp_valid=0, rsp_status=00, rsp_cycles=0, with counters and operand registers cleared.
REQ-034 SHALL give reset priority over all other inputs, including mid-operation (any state): start drops at that edge and the pending request is discarded.
REQ-035 SHALL drive req_ready=0 while rst is high and drive req_ready=1 in the first cycle after rst is released.

Structure
REQ-036 SHALL place the state enum, the rsp_status codes and the default widths in a shared package, gcd_pkg.
REQ-037 SHALL use no sub-modules; the gap and timeout counters are local to the module.

Verification
REQ-038 SHALL test A=148, B=18 with GAP_CYCLES=2, connected to gcd_top: start and data_in are 148 one cycle, then 0 for two cycles, then 18 one cycle; expect rsp_status=00 with rsp_cycles matching the observed done latency.
REQ-039 SHALL test A=0, B=18: no start pulse is ever seen; expect rsp_valid the cycle after acceptance with status 10 and cycles 0.
REQ-040 SHALL test with a stub core that never asserts done and TIMEOUT=16: expect status 01 and rsp_cycles=15.
REQ-041 SHALL test rst asserted in GAP after the A pulse: expect start=0 and req_ready=0 at that edge, then a new pair 12/8 completing normally.
REQ-042 SHALL test done pulsed during GAP, then again 5 cycles after LOAD_B: the first pulse is ignored and rsp_cycles=5.
REQ-043 SHALL test rsp_ready held low for 10 cycles: rsp_valid, rsp_status and rsp_cycles stay stable, and req_ready stays low until the handshake.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD operand loader: FSM states,
// response status codes and the counter saturation helper.
package gcd_pkg;

   localparam int DEF_DATA_W     = 16;
   localparam int DEF_GAP_CYCLES = 2;
   localparam int DEF_TIMEOUT    = 1024;
   localparam int CYCLES_W       = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_A    = 3'd1,
      GAP       = 3'd2,
      LOAD_B    = 3'd3,
      WAIT_DONE = 3'd4,
      RESP      = 3'd5
   } gcd_state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_TIMEOUT = 2'b01,
      ST_ZERO    = 2'b10
   } gcd_status_t;

   function automatic logic [CYCLES_W-1:0] sat_inc(input logic [CYCLES_W-1:0] v);
      return (v == {CYCLES_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/gcd_loader.sv
// Feeds an operand pair to a GCD core as two start strobes (A, gap, B),
// waits for done with a timeout, and returns status plus wait latency.
module gcd_loader
   import gcd_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [DATA_W-1:0]   req_a,
   input  logic [DATA_W-1:0]   req_b,
   output logic                start,
   output logic [DATA_W-1:0]   data_in,
   input  logic                done,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [1:0]          rsp_status,
   output logic [CYCLES_W-1:0] rsp_cycles
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   gcd_state_t          state_reg;
   logic [DATA_W-1:0]   b_reg;
   logic [GAP_W-1:0]    gap_cnt_reg;
   logic [TO_W-1:0]     to_cnt_reg;
   logic [CYCLES_W-1:0] wait_cnt_reg;

   // Gated by rst so the host never sees ready while reset is held.
   assign req_ready = (state_reg == IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         b_reg        <= '0;
         gap_cnt_reg  <= '0;
         to_cnt_reg   <= '0;
         wait_cnt_reg <= '0;
         start        <= 1'b0;
         data_in      <= '0;
         rsp_valid    <= 1'b0;
         rsp_status   <= ST_OK;
         rsp_cycles   <= '0;
      end else begin
         start   <= 1'b0;
         data_in <= '0;
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  // Operand A goes straight into the output register; only B waits.
                  b_reg <= req_b;
                  if (req_a == '0 || req_b == '0) begin
                     state_reg  <= RESP;
                     rsp_valid  <= 1'b1;
                     rsp_status <= ST_ZERO;
                     rsp_cycles <= '0;
                  end else begin
                     state_reg <= LOAD_A;
                     start     <= 1'b1;
                     data_in   <= req_a;
                  end
               end
            end
            LOAD_A: begin
               gap_cnt_reg <= '0;
               if (GAP_CYCLES == 0) begin
                  state_reg <= LOAD_B;
                  start     <= 1'b1;
                  data_in   <= b_reg;
               end else begin
                  state_reg <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt_reg == GAP_LAST) begin
                  state_reg <= LOAD_B;
                  start     <= 1'b1;
                  data_in   <= b_reg;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 1'b1;
               end
            end
            LOAD_B: begin
               state_reg    <= WAIT_DONE;
               to_cnt_reg   <= '0;
               wait_cnt_reg <= '0;
            end
            WAIT_DONE: begin
               // done wins over a timeout landing in the same cycle.
               if (done) begin
                  state_reg  <= RESP;
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_OK;
                  rsp_cycles <= wait_cnt_reg;
               end else if (to_cnt_reg == TO_LAST) begin
                  state_reg  <= RESP;
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_TIMEOUT;
                  rsp_cycles <= wait_cnt_reg;
               end else begin
                  to_cnt_reg   <= to_cnt_reg + 1'b1;
                  wait_cnt_reg <= sat_inc(wait_cnt_reg);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_reg <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_loader.sv
// Randomised bench for gcd_loader: the bench plays host and GCD core and
// compares strobes and responses against a latency-based response model.
module tb_gcd_loader;
   import gcd_pkg::*;

   localparam int DW  = 16;
   localparam int GAP = 2;
   localparam int TO  = 16;
   localparam int NEVER = 100000;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [DW-1:0] req_a;
   logic [DW-1:0] req_b;
   logic          start;
   logic [DW-1:0] data_in;
   logic          done;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_status;
   logic [15:0]   rsp_cycles;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   gcd_loader #(.DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .start(start), .data_in(data_in), .done(done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_status(rsp_status), .rsp_cycles(rsp_cycles)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // lat = number of low-done cycles the core spends before raising done.
   function automatic void model(input int a, input int b, input int lat,
                                 output int st, output int cyc);
      if (a == 0 || b == 0) begin
         st = 2; cyc = 0;
      end else if (lat < TO) begin
         st = 0; cyc = lat;
      end else begin
         st = 1; cyc = TO - 1;
      end
   endfunction

   task automatic run_txn(input int a, input int b, input int lat,
                          input bit gap_done, input int hold);
      int st, cyc, j;
      model(a, b, lat, st, cyc);
      @(negedge clk);
      check_eq("req_ready_idle", 32'(req_ready), 1);
      req_valid = 1'b1; req_a = DW'(a); req_b = DW'(b);
      @(negedge clk);
      req_valid = 1'b0; req_a = DW'($urandom); req_b = DW'($urandom);
      check_eq("req_ready_busy", 32'(req_ready), 0);
      if (st == 2) begin
         check_eq("zero_no_start", 32'(start), 0);
      end else begin
         check_eq("start_a", 32'(start), 1);
         check_eq("data_a", 32'(data_in), 32'(a));
         for (int g = 0; g < GAP; g++) begin
            @(negedge clk);
            done = gap_done && (g == 0);
            check_eq("gap_start", 32'(start), 0);
            check_eq("gap_data", 32'(data_in), 0);
         end
         @(negedge clk);
         done = 1'b0;
         check_eq("start_b", 32'(start), 1);
         check_eq("data_b", 32'(data_in), 32'(b));
         @(negedge clk);
         j = 0;
         while (rsp_valid !== 1'b1 && j < TO + 8) begin
            check_eq("wait_start", 32'(start), 0);
            done = (j == lat);
            @(negedge clk);
            done = 1'b0;
            j++;
         end
      end
      check_eq("rsp_valid", 32'(rsp_valid), 1);
      check_eq("rsp_status", 32'(rsp_status), 32'(st));
      check_eq("rsp_cycles", 32'(rsp_cycles), 32'(cyc));
      for (int h = 0; h < hold; h++) begin
         done = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_eq("hold_valid", 32'(rsp_valid), 1);
         check_eq("hold_status", 32'(rsp_status), 32'(st));
         check_eq("hold_cycles", 32'(rsp_cycles), 32'(cyc));
         check_eq("hold_ready", 32'(req_ready), 0);
      end
      done = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("post_valid", 32'(rsp_valid), 0);
      check_eq("post_req_ready", 32'(req_ready), 1);
      check_eq("post_status", 32'(rsp_status), 32'(st));
      check_eq("post_cycles", 32'(rsp_cycles), 32'(cyc));
      $display("txn a=%0d b=%0d lat=%0d gap_done=%0d hold=%0d -> status=%0d cycles=%0d",
               a, b, lat, gap_done, hold, st, cyc);
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_start", 32'(start), 0);
      check_eq("rst_data", 32'(data_in), 0);
      check_eq("rst_req_ready", 32'(req_ready), 0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
      check_eq("rst_rsp_status", 32'(rsp_status), 0);
      check_eq("rst_rsp_cycles", 32'(rsp_cycles), 0);
   endtask

   initial begin
      int a, b, lat;
      rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
      done = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      @(negedge clk);
      check_eq("req_ready_after_rst", 32'(req_ready), 1);

      run_txn(148, 18, 7, 1'b0, 0);
      run_txn(0, 18, 0, 1'b0, 2);
      run_txn(5, 0, 0, 1'b0, 0);
      run_txn(9, 6, NEVER, 1'b0, 0);
      run_txn(27, 9, TO - 1, 1'b0, 0);
      run_txn(27, 9, TO, 1'b0, 0);
      run_txn(7, 3, 0, 1'b0, 1);

      // Reset while in the gap after the A strobe.
      @(negedge clk);
      req_valid = 1'b1; req_a = 16'd148; req_b = 16'd18;
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("rstgap_start_a", 32'(start), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      @(negedge clk);
      check_eq("rstgap_req_ready", 32'(req_ready), 1);
      $display("txn reset asserted in GAP, pending pair 148/18 discarded");
      run_txn(12, 8, 3, 1'b0, 0);

      run_txn(21, 14, 5, 1'b1, 0);
      run_txn(30, 12, 4, 1'b0, 10);

      for (int t = 0; t < 25; t++) begin
         a = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 65535));
         b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 65535));
         lat = int'($urandom_range(0, TO + 3));
         run_txn(a, b, lat, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
